down_count_checker: RTL and testbench
=====================================

# down_count_checker

Downstream monitor for the 4-bit free-running down counter. Samples the counter value every valid cycle and locks onto the decrement sequence. Once locked, it flags broken decrements, emits a one-cycle terminal-count pulse at zero, and counts 0→all-ones wraps. It feeds status and wrap count to the rest of the design and latches a fault after repeated sequence errors.

## Interface
- WIDTH, 4: width of the monitored count.
- WRAP_W, 8: width of the wrap counter.
- ERR_LIMIT, 3: number of tracked errors that forces FAULT; range 1..15.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- cnt_valid  input  1  cnt_in is sampled this cycle.
- cnt_in  input  WIDTH  counter value under test.
- clr_err  input  1  synchronous clear of err, err_count and FAULT.
- state  output  2  IDLE=00, SYNC=01, TRACK=10, FAULT=11.
- locked  output  1  high while state==TRACK.
- tc_pulse  output  1  one-cycle pulse, zero sampled in TRACK.
- wrap_count  output  WRAP_W  number of tracked 0→all-ones wraps, modulo 2^WRAP_W.
- err  output  1  sticky error flag.
- err_count  output  4  number of tracked errors, saturating at 15.

## Operation
- Internal registers:
  - prev (WIDTH): last sampled value.
  - match (1 bit): count of correct decrements seen in SYNC.
- Expected value: exp = prev - 1 mod 2^WIDTH, so 0 expects all-ones.
- A "reload" is a sample equal to all-ones when exp ≠ all-ones. This is how the counter's own reset appears on the bus.
- IDLE:
  - Valid sample: prev←cnt_in, match←0, go to SYNC.
- SYNC:
  - Valid sample == exp: if match==1, go to TRACK; otherwise match←1.
  - Any other valid sample, including a reload: match←0. No error is counted.
  - prev←cnt_in on every valid sample.
- TRACK:
  - Valid sample == exp: stay in TRACK.
  - If prev==0 and cnt_in==all-ones: wrap_count += 1.
  - If cnt_in==0: tc_pulse=1 on the next cycle.
  - Reload: go to SYNC, match←0. No error is counted.
  - Other mismatch: err←1, err_count += 1 (saturating), go to SYNC, match←0.
  - If the post-increment err_count ≥ ERR_LIMIT: go to FAULT instead of SYNC.
  - prev←cnt_in on every valid sample.
- FAULT:
  - Ignores samples. tc_pulse and wrap_count are frozen.
  - clr_err=1: go to IDLE and clear err and err_count.
- clr_err in other states clears err and err_count only; state is unchanged.
- clr_err together with a TRACK mismatch in the same cycle: the clear applies first. Result is err=1, err_count=1.
- cnt_valid=0: no state, prev, match or counter change; tc_pulse=0.

## Timing
- All outputs are registered.
- Each effect is visible after the rising edge on which cnt_valid=1 was sampled. Latency is 1 cycle.
- Reset asserted (low): immediately, independent of clk:
  - state=IDLE, locked=0, tc_pulse=0, wrap_count=0, err=0, err_count=0, prev=0, match=0.
- Reset release: takes effect at the first clk edge after reset goes high. Reset mid-TRACK discards lock and all counts.
- Lock needs at least 3 consecutive valid samples: first sample plus two correct decrements.
- tc_pulse is high exactly one cycle per zero sample. It is never high in IDLE, SYNC or FAULT.
- wrap_count rolls from 2^WRAP_W-1 to 0 without a flag.

## Test plan
- Reset low for 2 cycles, then feed 15,14,13,12 with cnt_valid=1:
  - state=SYNC after 15; locked=1 after 13; err=0.
- Locked, feed ...,1,0,15,14:
  - tc_pulse=1 for exactly the one cycle after the 0 sample.
  - wrap_count goes 0→1 after the 15 sample.
- Locked at prev=9, feed 15:
  - state=SYNC, err=0, err_count=0.
  - Relocks after 14,13.
- Locked, inject jumps 9→5, then relock and 8→2, then relock and 6→6 (ERR_LIMIT=3):
  - err_count goes 1, 2, 3; err=1; state=FAULT after the third.
  - clr_err=1 gives state=IDLE, err=0, err_count=0.
- Locked, with a 7→3 mismatch and clr_err=1 in the same cycle:
  - err=1, err_count=1, state=SYNC.
- Locked with wrap_count=5, drop cnt_valid for 4 cycles, then assert reset mid-stream:
  - While cnt_valid=0: outputs hold, tc_pulse=0.
  - On reset: all outputs 0 and state=IDLE immediately, before the next clk edge.

Source files
------------

// File: rtl/down_count_checker.sv
// Monitor for a free-running down counter: locks onto the decrement sequence,
// flags broken decrements, pulses at terminal count and counts wraps.
module down_count_checker #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned WRAP_W    = 8,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cnt_valid,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              clr_err,
  output logic [1:0]        state,
  output logic              locked,
  output logic              tc_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err,
  output logic [3:0]        err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SYNC  = 2'b01,
    TRACK = 2'b10,
    FAULT = 2'b11
  } state_t;

  state_t           st;
  logic [WIDTH-1:0] prev;
  logic             match;

  logic [WIDTH-1:0] exp_val;
  logic             is_match;
  logic             is_ones;
  logic             is_reload;
  logic [3:0]       err_base;
  logic [3:0]       err_inc;

  assign state = st;

  always_comb begin
    exp_val   = prev - WIDTH'(1);
    is_match  = (cnt_in == exp_val);
    is_ones   = (cnt_in == '1);
    is_reload = is_ones && (exp_val != '1);
    // A clear in the same cycle as a mismatch is applied before the increment.
    err_base  = clr_err ? 4'd0 : err_count;
    err_inc   = (err_base == 4'hF) ? 4'hF : err_base + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= IDLE;
      locked     <= 1'b0;
      tc_pulse   <= 1'b0;
      wrap_count <= '0;
      err        <= 1'b0;
      err_count  <= '0;
      prev       <= '0;
      match      <= 1'b0;
    end else begin
      tc_pulse <= 1'b0;
      if (clr_err) begin
        err       <= 1'b0;
        err_count <= '0;
      end
      unique case (st)
        IDLE: begin
          if (cnt_valid) begin
            prev   <= cnt_in;
            match  <= 1'b0;
            st     <= SYNC;
            locked <= 1'b0;
          end
        end
        SYNC: begin
          if (cnt_valid) begin
            prev <= cnt_in;
            if (is_match) begin
              if (match) begin
                st     <= TRACK;
                locked <= 1'b1;
              end else begin
                match <= 1'b1;
              end
            end else begin
              match <= 1'b0;
            end
          end
        end
        TRACK: begin
          if (cnt_valid) begin
            prev <= cnt_in;
            if (is_match) begin
              if (prev == '0)
                wrap_count <= wrap_count + WRAP_W'(1);
              if (cnt_in == '0)
                tc_pulse <= 1'b1;
            end else if (is_reload) begin
              st     <= SYNC;
              locked <= 1'b0;
              match  <= 1'b0;
            end else begin
              err       <= 1'b1;
              err_count <= err_inc;
              match     <= 1'b0;
              locked    <= 1'b0;
              st        <= (32'(err_inc) >= ERR_LIMIT) ? FAULT : SYNC;
            end
          end
        end
        FAULT: begin
          if (clr_err)
            st <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_count_checker.sv
// Directed plus randomized bench for down_count_checker with a behavioural model.
module tb_down_count_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       cnt_valid;
  logic [3:0] cnt_in;
  logic       clr_err;
  logic [1:0] state;
  logic       locked;
  logic       tc_pulse;
  logic [7:0] wrap_count;
  logic       err;
  logic [3:0] err_count;

  int checks = 0;
  int errors = 0;

  // Reference model: 0=IDLE 1=SYNC 2=TRACK 3=FAULT
  int m_state, m_prev, m_match, m_wrap, m_err, m_ec, m_tc;
  int cur;

  always #5 clk = ~clk;

  down_count_checker #(.WIDTH(4), .WRAP_W(8), .ERR_LIMIT(3)) dut (
    .clk(clk), .reset(reset), .cnt_valid(cnt_valid), .cnt_in(cnt_in),
    .clr_err(clr_err), .state(state), .locked(locked), .tc_pulse(tc_pulse),
    .wrap_count(wrap_count), .err(err), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},      32'(state),      32'(m_state));
    chk({tag, ".locked"},     32'(locked),     32'(m_state == 2));
    chk({tag, ".tc_pulse"},   32'(tc_pulse),   32'(m_tc));
    chk({tag, ".wrap_count"}, 32'(wrap_count), 32'(m_wrap));
    chk({tag, ".err"},        32'(err),        32'(m_err));
    chk({tag, ".err_count"},  32'(err_count),  32'(m_ec));
  endtask

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_match = 0; m_wrap = 0;
    m_err = 0; m_ec = 0; m_tc = 0;
  endtask

  task automatic model_step(input logic v, input int x, input logic c);
    int e;
    m_tc = 0;
    if (c) begin m_err = 0; m_ec = 0; end
    e = (m_prev + 15) % 16;
    case (m_state)
      0: if (v) begin m_prev = x; m_match = 0; m_state = 1; end
      1: if (v) begin
           if (x == e) begin
             if (m_match == 1) m_state = 2; else m_match = 1;
           end else m_match = 0;
           m_prev = x;
         end
      2: if (v) begin
           if (x == e) begin
             if (m_prev == 0) m_wrap = (m_wrap + 1) % 256;
             if (x == 0) m_tc = 1;
           end else if (x == 15) begin
             m_state = 1; m_match = 0;
           end else begin
             m_err = 1;
             m_ec = (m_ec < 15) ? m_ec + 1 : 15;
             m_match = 0;
             m_state = (m_ec >= 3) ? 3 : 1;
           end
           m_prev = x;
         end
      3: if (c) m_state = 0;
      default: ;
    endcase
  endtask

  task automatic drive(input logic v, input int x, input logic c, input string tag);
    @(negedge clk);
    cnt_valid = v;
    cnt_in    = x[3:0];
    clr_err   = c;
    if (v) cur = x;
    @(posedge clk);
    model_step(v, x, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0; cnt_valid = 1'b0; cnt_in = '0; clr_err = 1'b0; cur = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) reset = 1'b1;

    // Initial lock
    drive(1, 15, 0, "lock15"); chk("sync_after_15", 32'(state), 32'd1);
    drive(1, 14, 0, "lock14");
    drive(1, 13, 0, "lock13"); chk("locked_after_13", 32'(locked), 32'd1);
    drive(1, 12, 0, "lock12"); chk("no_err_lock", 32'(err), 32'd0);

    // Terminal count and wrap
    for (int v = 11; v >= 0; v--) drive(1, v, 0, "down");
    chk("tc_after_zero", 32'(tc_pulse), 32'd1);
    drive(1, 15, 0, "wrap15");
    chk("tc_one_cycle", 32'(tc_pulse), 32'd0);
    chk("wrap_one", 32'(wrap_count), 32'd1);
    drive(1, 14, 0, "wrap14");

    // Reload from prev=9
    for (int v = 13; v >= 9; v--) drive(1, v, 0, "to9");
    drive(1, 15, 0, "reload");
    chk("reload_sync", 32'(state), 32'd1);
    chk("reload_no_err", 32'(err_count), 32'd0);
    drive(1, 14, 0, "relock14");
    drive(1, 13, 0, "relock13");
    chk("relocked", 32'(locked), 32'd1);

    // Three tracked errors reach FAULT
    for (int v = 12; v >= 9; v--) drive(1, v, 0, "to9b");
    drive(1, 5, 0, "jump9_5"); chk("ec1", 32'(err_count), 32'd1);
    drive(1, 4, 0, "rl4"); drive(1, 3, 0, "rl3");
    for (int v = 2; v >= 0; v--) drive(1, v, 0, "dn");
    for (int v = 15; v >= 8; v--) drive(1, v, 0, "dn");
    drive(1, 2, 0, "jump8_2"); chk("ec2", 32'(err_count), 32'd2);
    drive(1, 1, 0, "rl1"); drive(1, 0, 0, "rl0");
    for (int v = 15; v >= 6; v--) drive(1, v, 0, "dn");
    drive(1, 6, 0, "jump6_6");
    chk("ec3", 32'(err_count), 32'd3);
    chk("fault", 32'(state), 32'd3);
    drive(1, 5, 0, "fault_ign5");
    drive(1, 4, 0, "fault_ign4");
    drive(0, 0, 1, "fault_clr");
    chk("clr_idle", 32'(state), 32'd0);
    chk("clr_ec", 32'(err_count), 32'd0);

    // Clear coincident with a mismatch
    drive(1, 10, 0, "a10"); drive(1, 9, 0, "a9"); drive(1, 8, 0, "a8");
    drive(1, 7, 0, "a7"); drive(1, 5, 0, "a_err");
    drive(1, 4, 0, "a4"); drive(1, 3, 0, "a3");
    for (int v = 2; v >= 0; v--) drive(1, v, 0, "dn");
    for (int v = 15; v >= 7; v--) drive(1, v, 0, "dn");
    drive(1, 3, 1, "clr_mismatch");
    chk("clr_mm_ec", 32'(err_count), 32'd1);
    chk("clr_mm_err", 32'(err), 32'd1);
    chk("clr_mm_sync", 32'(state), 32'd1);

    // Count on to wrap_count=5, then pause and reset mid-stream
    drive(1, 2, 0, "b2"); drive(1, 1, 0, "b1");
    for (int i = 0; i < 64 && m_wrap != 5; i++) drive(1, (cur + 15) % 16, 0, "to_wrap5");
    chk("wrap_five", 32'(wrap_count), 32'd5);
    for (int i = 0; i < 4; i++) drive(0, int'($urandom_range(0, 15)), 0, "hold");
    chk("hold_tc", 32'(tc_pulse), 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1 check_all("async_reset");
    chk("async_reset_idle", 32'(state), 32'd0);
    @(negedge clk) reset = 1'b1;

    // Randomized counter stream with glitches, reloads, gaps and clears
    for (int i = 0; i < 500; i++) begin
      int r, x;
      logic v, c;
      r = int'($urandom_range(0, 99));
      v = (r < 85);
      if (r < 5)       x = int'($urandom_range(0, 15));
      else if (r < 8)  x = 15;
      else             x = (cur + 15) % 16;
      c = ($urandom_range(0, 39) == 0);
      drive(v, x, c, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
